adxl362_int_ctrl: RTL and testbench

Parametrised interrupt controller for the ADXL362 behavioural model. It replaces the fixed two-pin, two-source INT1/INT2 mapping with:
- NUM_SRC status sources, each either latched (sticky) or level-following.
- NUM_INT output pins, each with its own enable map and polarity bit.
- A per-pin minimum-pulse-width stretcher.
It sits between the sample/FIFO event logic and the register file: its status vector feeds the STATUS register, and its pins drive the INT outputs.

---
 rtl/adxl362_int_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_adxl362_int_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adxl362_int_ctrl.sv
// Parametrised interrupt controller: sticky/level status sources and per-pin enable maps with polarity.
// Each pin also has a minimum-pulse stretcher. Optional lost-event flags are built when ADXL362_INT_OVERRUN_EN is defined.
module adxl362_int_ctrl #(
    parameter int NUM_SRC   = 7,
    parameter int NUM_INT   = 2,
    parameter int MIN_PULSE = 4,
    parameter int CNT_W     = 8
) (
    input  logic                         clk_16mhz,
    input  logic                         rst,
    input  logic [NUM_SRC-1:0]           src_set,
    input  logic [NUM_SRC-1:0]           src_level,
    input  logic [NUM_SRC-1:0]           src_clr,
    input  logic [NUM_SRC-1:0]           latch_mode,
    input  logic [NUM_INT*(NUM_SRC+1)-1:0] intmap,
    output logic [NUM_SRC-1:0]           status,
    output logic [NUM_INT-1:0]           int_out,
    output logic [NUM_INT-1:0]           int_edge,
    output logic [NUM_SRC-1:0]           overrun
);

    localparam int FW = NUM_SRC + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STRETCH = 2'd1,
        HOLD    = 2'd2
    } pin_state_e;

    logic [NUM_SRC-1:0] status_r;
    logic [NUM_SRC-1:0] status_nxt_s;

    // Next status: sticky bits with set-over-clear priority, level bits follow their input.
    always_comb begin
        status_nxt_s = status_r;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (latch_mode[i]) begin
                if (src_set[i]) begin
                    status_nxt_s[i] = 1'b1;
                end else if (src_clr[i]) begin
                    status_nxt_s[i] = 1'b0;
                end else begin
                    status_nxt_s[i] = status_r[i];
                end
            end else begin
                status_nxt_s[i] = src_level[i];
            end
        end
    end

    // Status register.
    always_ff @(posedge clk_16mhz or posedge rst) begin
        if (rst) begin
            status_r <= {NUM_SRC{1'b0}};
        end else begin
            status_r <= status_nxt_s;
        end
    end

    assign status = status_r;

`ifdef ADXL362_INT_OVERRUN_EN
    logic [NUM_SRC-1:0] overrun_r;
    logic [NUM_SRC-1:0] overrun_nxt_s;

    // A set on an already-pending sticky bit with no clear in the same cycle means an event was lost.
    always_comb begin
        overrun_nxt_s = overrun_r;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_set[i] && latch_mode[i] && status_r[i] && !src_clr[i]) begin
                overrun_nxt_s[i] = 1'b1;
            end else if (src_clr[i]) begin
                overrun_nxt_s[i] = 1'b0;
            end else begin
                overrun_nxt_s[i] = overrun_r[i];
            end
        end
    end

    // Overrun flag register.
    always_ff @(posedge clk_16mhz or posedge rst) begin
        if (rst) begin
            overrun_r <= {NUM_SRC{1'b0}};
        end else begin
            overrun_r <= overrun_nxt_s;
        end
    end

    assign overrun = overrun_r;
`else
    assign overrun = {NUM_SRC{1'b0}};
`endif

    for (genvar k = 0; k < NUM_INT; k++) begin : g_pin
        pin_state_e         state_r;
        pin_state_e         next_state_s;
        logic [CNT_W-1:0]   cnt_r;
        logic [CNT_W-1:0]   cnt_nxt_s;
        logic               req_s;
        logic               int_low_s;
        logic               asserted_s;
        logic               edge_s;
        logic               out_r;
        logic               edge_r;

        assign req_s     = |(status_r & intmap[k*FW +: NUM_SRC]);
        assign int_low_s = intmap[k*FW + NUM_SRC];

        // Pin state and stretch counter register.
        always_ff @(posedge clk_16mhz or posedge rst) begin
            if (rst) begin
                state_r <= IDLE;
                cnt_r   <= {CNT_W{1'b0}};
            end else begin
                state_r <= next_state_s;
                cnt_r   <= cnt_nxt_s;
            end
        end

        // Next state: re-requests during STRETCH neither restart the counter nor re-enter IDLE.
        always_comb begin
            next_state_s = state_r;
            cnt_nxt_s    = cnt_r;
            case (state_r)
                IDLE: begin
                    if (req_s) begin
                        next_state_s = STRETCH;
                        cnt_nxt_s    = CNT_W'(1);
                    end else begin
                        next_state_s = IDLE;
                        cnt_nxt_s    = {CNT_W{1'b0}};
                    end
                end
                STRETCH: begin
                    if (cnt_r == CNT_W'(MIN_PULSE)) begin
                        next_state_s = req_s ? HOLD : IDLE;
                        cnt_nxt_s    = {CNT_W{1'b0}};
                    end else begin
                        next_state_s = STRETCH;
                        cnt_nxt_s    = cnt_r + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (req_s) begin
                        next_state_s = HOLD;
                    end else begin
                        next_state_s = IDLE;
                    end
                end
                default: begin
                    next_state_s = IDLE;
                    cnt_nxt_s    = {CNT_W{1'b0}};
                end
            endcase
        end

        // Outputs derive from the next state so the pin lands on the same edge as the transition.
        always_comb begin
            asserted_s = 1'b0;
            edge_s     = 1'b0;
            if (next_state_s != IDLE) begin
                asserted_s = 1'b1;
            end else begin
                asserted_s = 1'b0;
            end
            if ((state_r == IDLE) && (next_state_s == STRETCH)) begin
                edge_s = 1'b1;
            end else begin
                edge_s = 1'b0;
            end
        end

        // Pin output register with polarity applied.
        always_ff @(posedge clk_16mhz or posedge rst) begin
            if (rst) begin
                out_r  <= 1'b0;
                edge_r <= 1'b0;
            end else begin
                out_r  <= asserted_s ^ int_low_s;
                edge_r <= edge_s;
            end
        end

        assign int_out[k]  = out_r;
        assign int_edge[k] = edge_r;
    end

endmodule

// File: tb/tb_adxl362_int_ctrl.sv
// Self-checking bench for adxl362_int_ctrl: a cycle-level behavioural model compared every cycle,
// plus directed literal checks for reset, latency, pulse width, set/clear priority and polarity.
module tb_adxl362_int_ctrl;

    localparam int NS = 7;
    localparam int NI = 2;
    localparam int MP = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [NS-1:0] src_set, src_level, src_clr, latch_mode;
    logic [NI*(NS+1)-1:0] intmap;
    logic [NS-1:0] status, overrun;
    logic [NI-1:0] int_out, int_edge;

    int checks = 0;
    int passed = 0;

    adxl362_int_ctrl #(.NUM_SRC(NS), .NUM_INT(NI), .MIN_PULSE(MP), .CNT_W(8)) dut (
        .clk_16mhz (clk),
        .rst       (rst),
        .src_set   (src_set),
        .src_level (src_level),
        .src_clr   (src_clr),
        .latch_mode(latch_mode),
        .intmap    (intmap),
        .status    (status),
        .int_out   (int_out),
        .int_edge  (int_edge),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: pulse age counts asserted cycles; a pin stays up while younger than MP or requested.
    logic [NS-1:0] m_status, m_ovr;
    logic [NI-1:0] m_out, m_edge;
    bit            m_act [NI];
    int            m_age [NI];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_status <= '0;
            m_ovr    <= '0;
            m_out    <= '0;
            m_edge   <= '0;
            for (int k = 0; k < NI; k++) begin
                m_act[k] <= 1'b0;
                m_age[k] <= 0;
            end
        end else begin
            for (int k = 0; k < NI; k++) begin
                logic [NS-1:0] en;
                bit req, low, act_n, edge_n;
                int age_n;
                en     = intmap[k*(NS+1) +: NS];
                low    = intmap[k*(NS+1) + NS];
                req    = ((m_status & en) != '0);
                edge_n = 1'b0;
                act_n  = 1'b0;
                age_n  = 0;
                if (!m_act[k]) begin
                    if (req) begin
                        act_n  = 1'b1;
                        age_n  = 1;
                        edge_n = 1'b1;
                    end
                end else if (m_age[k] < MP || req) begin
                    act_n = 1'b1;
                    age_n = m_age[k] + 1;
                end
                m_act[k]  <= act_n;
                m_age[k]  <= age_n;
                m_out[k]  <= act_n ^ low;
                m_edge[k] <= edge_n;
            end
            for (int i = 0; i < NS; i++) begin
                if (latch_mode[i]) begin
                    m_status[i] <= src_set[i] ? 1'b1 : (src_clr[i] ? 1'b0 : m_status[i]);
                end else begin
                    m_status[i] <= src_level[i];
                end
`ifdef ADXL362_INT_OVERRUN_EN
                if (src_set[i] && latch_mode[i] && m_status[i] && !src_clr[i]) m_ovr[i] <= 1'b1;
                else if (src_clr[i]) m_ovr[i] <= 1'b0;
`endif
            end
        end
    end

    // Compare DUT against the model on every falling edge outside reset.
    always @(negedge clk) begin
        if (!rst) begin
            chk("model_status",   32'(status),   32'(m_status));
            chk("model_int_out",  32'(int_out),  32'(m_out));
            chk("model_int_edge", 32'(int_edge), 32'(m_edge));
            chk("model_overrun",  32'(overrun),  32'(m_ovr));
        end
    end

    initial begin
        int n_hi;
        int n_edge;
        rst        = 1'b1;
        src_set    = '0;
        src_level  = '0;
        src_clr    = '0;
        latch_mode = '0;
        intmap     = 16'h0000;

        // 1. reset and idle polarity
        tick();
        chk("reset_status",  32'(status),   32'h0);
        chk("reset_int_out", 32'(int_out),  32'h0);
        chk("reset_edge",    32'(int_edge), 32'h0);
        intmap = 16'h8101;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        chk("idle_int_out", 32'(int_out),  32'h2);
        chk("idle_status",  32'(status),   32'h0);
        chk("idle_edge",    32'(int_edge), 32'h0);

        // 2. sticky source 0: 1-cycle to status, 2 cycles to pin
        latch_mode = 7'h01;
        src_set    = 7'h01;
        tick();
        src_set = 7'h00;
        chk("set_status_t1", 32'(status[0]), 32'h1);
        chk("set_out_t1",    32'(int_out),   32'h2);
        tick();
        chk("set_out_t2",  32'(int_out),     32'h1);
        chk("set_edge_t2", 32'(int_edge[0]), 32'h1);
        repeat (8) tick();
        src_clr = 7'h01;
        tick();
        src_clr = 7'h00;
        tick();
        chk("clr_out_t12", 32'(int_out), 32'h2);

        // 3. level source 1, minimum pulse and long hold
        repeat (6) tick();
        intmap    = 16'h8102;
        src_level = 7'h02;
        tick();
        src_level = 7'h00;
        n_hi = 0; n_edge = 0;
        if (int_out[0]) n_hi++;
        if (int_edge[0]) n_edge++;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (int_out[0]) n_hi++;
            if (int_edge[0]) n_edge++;
        end
        chk("short_pulse_width", 32'(n_hi),   32'd4);
        chk("short_pulse_edges", 32'(n_edge), 32'd1);
        src_level = 7'h02;
        n_hi = 0; n_edge = 0;
        for (int c = 0; c < 17; c++) begin
            tick();
            if (c == 8) src_level = 7'h00;
            if (int_out[0]) n_hi++;
            if (int_edge[0]) n_edge++;
        end
        chk("long_pulse_width", 32'(n_hi),   32'd9);
        chk("long_pulse_edges", 32'(n_edge), 32'd1);

        // 4. set/clear priority and overrun
        intmap  = 16'h8101;
        src_set = 7'h01;
        tick();
        src_set = 7'h01;
        src_clr = 7'h01;
        tick();
        src_clr = 7'h00;
        chk("setclr_status",  32'(status[0]),  32'h1);
        chk("setclr_overrun", 32'(overrun[0]), 32'h0);
        tick();
        src_set = 7'h00;
`ifdef ADXL362_INT_OVERRUN_EN
        chk("overrun_set", 32'(overrun[0]), 32'h1);
`else
        chk("overrun_off", 32'(overrun[0]), 32'h0);
`endif
        src_clr = 7'h01;
        tick();
        src_clr = 7'h00;
        chk("overrun_clr", 32'(overrun), 32'h0);
        chk("status_clr",  32'(status),  32'h0);
        repeat (8) tick();

        // 5. asynchronous reset in STRETCH
        src_set = 7'h01;
        tick();
        src_set = 7'h00;
        tick();
        chk("pre_rst_out", 32'(int_out[0]), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_out",    32'(int_out),  32'h0);
        chk("async_rst_status", 32'(status),   32'h0);
        chk("async_rst_edge",   32'(int_edge), 32'h0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_out", 32'(int_out), 32'h2);

        // 6. polarity flip in HOLD, then enables cleared
        src_set = 7'h01;
        tick();
        src_set = 7'h00;
        repeat (6) tick();
        chk("hold_out", 32'(int_out[0]), 32'h1);
        intmap = 16'h8181;
        tick();
        chk("flip_out", 32'(int_out[0]), 32'h0);
        intmap = 16'h8180;
        tick();
        chk("noen_out", 32'(int_out[0]), 32'h1);
        repeat (3) tick();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
